// File: rtl/ctrl_sequencer.sv
// Registered control sequencer: state register, next-state logic and datapath strobes
// for the simple CPU, with multi-cycle ALU execute, memory stall, HALT/resume and retire count.
module ctrl_sequencer #(
    parameter int unsigned OPCODE_W   = 4,
    parameter int unsigned ALU_CYCLES = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [4:0]          state,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                alu_en,
    output logic                reg_we,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [4:0] {
        IDLE   = 5'b11111,
        FETCH  = 5'b10000,
        DECODE = 5'b00000,
        LOAD   = 5'b00001,
        MOV    = 5'b00010,
        EXEC   = 5'b00011,
        WB     = 5'b00101,
        BRANCH = 5'b00110,
        HALT   = 5'b01000
    } state_e;

    localparam logic [4:0] EXEC_INIT = 5'(ALU_CYCLES - 1);

    state_e             state_q, state_d;
    logic [4:0]         exec_q, exec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;

    always_comb begin
        state_d = state_q;
        exec_d  = exec_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (opcode == OPCODE_W'(0)) begin
                    state_d = LOAD;
                end else if (opcode == OPCODE_W'(1)) begin
                    state_d = MOV;
                end else if (opcode >= OPCODE_W'(2) && opcode <= OPCODE_W'(5)) begin
                    state_d = EXEC;
                    exec_d  = EXEC_INIT;
                end else if (opcode == OPCODE_W'(6)) begin
                    state_d = BRANCH;
                end else if (opcode == OPCODE_W'(7)) begin
                    state_d = HALT;
                    retire  = 1'b1;
                end else begin
                    // Unmapped opcodes behave as NOP and still retire.
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            LOAD: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            MOV, WB, BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            EXEC: begin
                if (exec_q != 5'd0) exec_d = exec_q - 5'd1;
                else                state_d = WB;
            end
            HALT:   if (start) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            exec_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exec_q  <= exec_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are decoded directly from the current state so they act in the same cycle.
    always_comb begin
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        case (state_q)
            FETCH: begin
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            LOAD:    reg_we  = mem_ready;
            MOV, WB: reg_we  = 1'b1;
            EXEC:    alu_en  = 1'b1;
            BRANCH:  pc_load = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign busy        = (state_q != IDLE) && (state_q != HALT);
    assign halted      = (state_q == HALT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios followed by random stimulus,
// all compared against an instruction-level reference model.
module tb_ctrl_sequencer;

    localparam int unsigned OW = 5;
    localparam int unsigned AC = 3;
    localparam int unsigned CW = 4;

    localparam logic [4:0] S_IDLE   = 5'b11111;
    localparam logic [4:0] S_FETCH  = 5'b10000;
    localparam logic [4:0] S_DECODE = 5'b00000;
    localparam logic [4:0] S_LOAD   = 5'b00001;
    localparam logic [4:0] S_MOV    = 5'b00010;
    localparam logic [4:0] S_EXEC   = 5'b00011;
    localparam logic [4:0] S_WB     = 5'b00101;
    localparam logic [4:0] S_BRANCH = 5'b00110;
    localparam logic [4:0] S_HALT   = 5'b01000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [OW-1:0] opcode = '0;
    logic          mem_ready = 1'b0;
    logic [4:0]    state;
    logic          ir_load, pc_inc, pc_load, alu_en, reg_we, busy, halted;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_state = S_IDLE;
    int         m_exec_seen = 0;
    int         m_retired = 0;

    int alu_seen = 0;
    int ir_seen = 0;
    int we_seen = 0;

    ctrl_sequencer #(.OPCODE_W(OW), .ALU_CYCLES(AC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .state(state), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .alu_en(alu_en), .reg_we(reg_we), .busy(busy), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic r, input logic s, input logic [OW-1:0] op, input logic mr);
        logic [4:0] exp_str;
        @(negedge clk);
        rst = r; start = s; opcode = op; mem_ready = mr;
        #1;
        exp_str = 5'b00000;
        if (m_state == S_FETCH && mr)                 exp_str = 5'b11000;
        if (m_state == S_LOAD && mr)                  exp_str = 5'b00001;
        if (m_state == S_MOV || m_state == S_WB)      exp_str = 5'b00001;
        if (m_state == S_EXEC)                        exp_str = 5'b00010;
        if (m_state == S_BRANCH)                      exp_str = 5'b00100;
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("strobes", 32'({ir_load, pc_inc, pc_load, alu_en, reg_we}), 32'(exp_str));
        check_eq("busy_halted", 32'({busy, halted}),
                 32'({(m_state != S_IDLE) && (m_state != S_HALT), m_state == S_HALT}));
        check_eq("instr_count", 32'(instr_count), 32'(m_retired % (1 << CW)));
        check_eq("strobe_excl",
                 32'(($countones({ir_load, pc_load, reg_we}) <= 1) && (!pc_inc || ir_load)), 32'd1);
        alu_seen += int'(alu_en);
        ir_seen  += int'(ir_load);
        we_seen  += int'(reg_we);

        if (r) begin
            m_state = S_IDLE; m_exec_seen = 0; m_retired = 0;
        end else if (m_state == S_IDLE || m_state == S_HALT) begin
            if (s) m_state = S_FETCH;
        end else if (m_state == S_FETCH) begin
            if (mr) m_state = S_DECODE;
        end else if (m_state == S_DECODE) begin
            if (op == 0)                 m_state = S_LOAD;
            else if (op == 1)            m_state = S_MOV;
            else if (op >= 2 && op <= 5) begin m_state = S_EXEC; m_exec_seen = 0; end
            else if (op == 6)            m_state = S_BRANCH;
            else if (op == 7)            begin m_state = S_HALT; m_retired++; end
            else                         begin m_state = S_FETCH; m_retired++; end
        end else if (m_state == S_EXEC) begin
            m_exec_seen++;
            if (m_exec_seen == int'(AC)) m_state = S_WB;
        end else if (m_state == S_LOAD) begin
            if (mr) begin m_state = S_FETCH; m_retired++; end
        end else begin
            m_state = S_FETCH; m_retired++;
        end
        @(posedge clk);
    endtask

    initial begin
        // Reset then idle, then start
        repeat (2) step(1'b1, 1'b0, '0, 1'b0);
        repeat (5) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);

        // ALU op: FETCH, DECODE, EXEC x AC, WB
        alu_seen = 0; we_seen = 0;
        repeat (3 + AC) step(1'b0, 1'b0, OW'(2), 1'b1);
        check_eq("alu_cycles", 32'(alu_seen), 32'(AC));
        check_eq("alu_wb_we", 32'(we_seen), 32'd1);
        #1 check_eq("alu_retired", 32'(instr_count), 32'd1);

        // Load with memory stalls in FETCH and LOAD
        ir_seen = 0; we_seen = 0;
        repeat (4) step(1'b0, 1'b0, OW'(0), 1'b0);
        step(1'b0, 1'b0, OW'(0), 1'b1);
        step(1'b0, 1'b0, OW'(0), 1'b1);
        repeat (2) step(1'b0, 1'b0, OW'(0), 1'b0);
        step(1'b0, 1'b0, OW'(0), 1'b1);
        check_eq("load_ir_pulses", 32'(ir_seen), 32'd1);
        check_eq("load_we_pulses", 32'(we_seen), 32'd1);

        // HALT, linger, resume
        repeat (2) step(1'b0, 1'b0, OW'(7), 1'b1);
        repeat (10) step(1'b0, 1'b0, OW'(7), 1'b1);
        step(1'b0, 1'b1, OW'(7), 1'b1);

        // Branch, then wide unmapped opcode as NOP
        repeat (3) step(1'b0, 1'b0, OW'(6), 1'b1);
        repeat (2) step(1'b0, 1'b0, OW'(5'b10110), 1'b1);

        // Reset during the second EXEC cycle must suppress the WB write
        we_seen = 0;
        repeat (3) step(1'b0, 1'b0, OW'(3), 1'b1);
        step(1'b1, 1'b0, OW'(3), 1'b1);
        repeat (3) step(1'b0, 1'b0, OW'(3), 1'b1);
        check_eq("rst_no_wb", 32'(we_seen), 32'd0);

        // Counter wrap via back-to-back MOVs
        step(1'b0, 1'b1, OW'(1), 1'b1);
        repeat ((1 << CW) - 1) repeat (3) step(1'b0, 1'b0, OW'(1), 1'b1);
        #1 check_eq("cnt_full", 32'(instr_count), 32'((1 << CW) - 1));
        repeat (3) step(1'b0, 1'b0, OW'(1), 1'b1);
        #1 check_eq("cnt_wrap", 32'(instr_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic          r, s, mr;
            logic [OW-1:0] op;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 3) == 0);
            op = ($urandom_range(0, 3) == 0) ? OW'($urandom_range(0, 31)) : OW'($urandom_range(0, 7));
            mr = ($urandom_range(0, 9) < 7);
            step(r, s, op, mr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
